// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock elastic buffer with a full-width occupancy
// count, programmable almost-full/almost-empty thresholds, selectable
// standard or first-word-fall-through read, and sticky overflow/underflow.
//
// Handshake: wen/ren are requests, and full/empty are the matching "not
// ready" indications, all decoded from registered state. A read is accepted
// (rd_ok) when ren && !empty. A write is accepted (wr_ok) when wen && !full,
// or when it is paired with an accepted read in the same cycle, so a full
// FIFO can still stream one in / one out. A rejected request is not an
// error for the logic. It only sets the sticky overflow/underflow flag.
// There is no FSM; the only state is the pointers, count, flags and data.
module param_sync_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 32,
  parameter int FWFT         = 0,
  parameter int AFULL_LEVEL  = FIFO_DEPTH - 2,
  parameter int AEMPTY_LEVEL = 2,
  parameter int CNT_WIDTH    = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_WIDTH = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0] LAST_PTR   = PTR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT  = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] AFULL_CNT  = CNT_WIDTH'(AFULL_LEVEL);
  localparam logic [CNT_WIDTH-1:0] AEMPTY_CNT = CNT_WIDTH'(AEMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [CNT_WIDTH-1:0]  count_d;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  rd_ok;
  logic                  wr_ok;

  // Pointers wrap by explicit compare so any depth works, not just 2^n.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_ONE;
  endfunction

  // Status flags decode only the registered count.
  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_CNT);
  assign almost_full  = (count_q >= AFULL_CNT);
  assign almost_empty = (count_q <= AEMPTY_CNT);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign rd_ok = ren && !empty;
  assign wr_ok = wen && (!full || rd_ok);

  // Occupancy update: +1 on write only, -1 on read only, hold otherwise.
  always_comb begin
    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CNT_ONE;
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Pointer, count and sticky error state; clear flushes without touching storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count_q <= count_d;
      if (wen && !wr_ok) begin
        overflow_q <= 1'b1;
      end
      if (ren && !rd_ok) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // Storage write; contents are never reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (wr_ok && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is always presented; zero when nothing is held.
      always_comb begin
        rdata = '0;
        if (!empty) begin
          rdata = mem[rd_ptr];
        end
      end
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rdata_q;

      // Registered read: capture the head entry on an accepted read.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata_q <= '0;
        end else if (clear) begin
          rdata_q <= '0;
        end else if (rd_ok) begin
          rdata_q <= mem[rd_ptr];
        end
      end

      assign rdata = rdata_q;
    end
  endgenerate

endmodule
